// File: rtl/obstacle_speed_scheduler.sv
// obstacle_speed_scheduler: variable-rate move_tick generator for the obstacle/background scroll
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   game_tick          60 Hz single-cycle tick
//   game_start_pulse   start/restart a run
//   game_over_pulse    crash; freezes scrolling (wins over a simultaneous start)
//   move_tick          registered single-cycle pulse, one clk after the game_tick that overflows the accumulator
//   speed_level        current speed level 0..MAX_LEVEL
//   sched_state        0=IDLE, 1=RUN, 2=FROZEN
// Optional: define SPEED_SCHED_ATTRACT_EN to scroll at BASE_RATE while IDLE (title screen).
module obstacle_speed_scheduler #(
  parameter int ACC_W       = 8,
  parameter int BASE_RATE   = 128,
  parameter int RATE_STEP   = 16,
  parameter int MAX_LEVEL   = 7,
  parameter int LEVEL_TICKS = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_tick,
  input  logic       game_start_pulse,
  input  logic       game_over_pulse,
  output logic       move_tick,
  output logic [2:0] speed_level,
  output logic [1:0] sched_state
);
  localparam int CNT_W = $clog2(LEVEL_TICKS);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic move_q, move_d;
  logic [ACC_W:0] rate, sum;
  logic adv, wrap;
  always_comb begin
    // level only scales the rate in RUN; attract mode scrolls at the base rate
    rate = (ACC_W+1)'(BASE_RATE) + (state_q == RUN ? (ACC_W+1)'(level_q) * (ACC_W+1)'(RATE_STEP) : '0);
    sum = {1'b0, acc_q} + rate;
    wrap = cnt_q == CNT_W'(LEVEL_TICKS - 1);
`ifdef SPEED_SCHED_ATTRACT_EN
    adv = game_tick && (state_q == RUN || state_q == IDLE);
`else
    adv = game_tick && state_q == RUN;
`endif
    state_d = state_q;
    acc_d = acc_q;
    level_d = level_q;
    cnt_d = cnt_q;
    move_d = 1'b0;
    // over has priority: a coincident start or tick is dropped entirely
    if (game_over_pulse) state_d = state_q == RUN ? FROZEN : state_q;
    else if (game_start_pulse) begin
      state_d = RUN;
      acc_d = '0;
      level_d = '0;
      cnt_d = '0;
    end else if (adv) begin
      acc_d = sum[ACC_W-1:0];
      move_d = sum[ACC_W];
      if (state_q == RUN) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        level_d = (wrap && level_q < 3'(MAX_LEVEL)) ? level_q + 3'd1 : level_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      move_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      move_q <= move_d;
    end
  end
  assign move_tick = move_q;
  assign speed_level = level_q;
  assign sched_state = state_q;
endmodule

// File: tb/tb_obstacle_speed_scheduler.sv
// tb_obstacle_speed_scheduler: randomized self-checking bench against an arithmetic model of the scheduler
module tb_obstacle_speed_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic game_tick = 1'b0;
  logic game_start_pulse = 1'b0;
  logic game_over_pulse = 1'b0;
  logic move_tick;
  logic [2:0] speed_level;
  logic [1:0] sched_state;
  int total = 0;
  int bad = 0;
  int m_state = 0;
  int m_ticks = 0;
  longint m_total = 0;
  bit exp_move = 1'b0;

  obstacle_speed_scheduler dut (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick),
    .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
    .move_tick(move_tick), .speed_level(speed_level), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  // level is simply the number of completed 600-tick periods in this run, capped at 7
  function automatic int lvl(input int n);
    return (n / 600 > 7) ? 7 : n / 600;
  endfunction

  // one clock of stimulus, then advance the model; moves happen when the running total
  // of rates crosses a multiple of 256
  task automatic cyc(input bit t, input bit s, input bit o);
    int r;
    game_tick = t;
    game_start_pulse = s;
    game_over_pulse = o;
    @(posedge clk);
    #1;
    game_tick = 0;
    game_start_pulse = 0;
    game_over_pulse = 0;
    exp_move = 0;
    if (o) begin
      if (m_state == 1) m_state = 2;
    end else if (s) begin
      m_state = 1;
      m_total = 0;
      m_ticks = 0;
    end else if (t && m_state == 1) begin
      r = 128 + 16 * lvl(m_ticks);
      exp_move = ((m_total + r) / 256) != (m_total / 256);
      m_total += r;
      m_ticks++;
    end
`ifdef SPEED_SCHED_ATTRACT_EN
    else if (t && m_state == 0) begin
      exp_move = ((m_total + 128) / 256) != (m_total / 256);
      m_total += 128;
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_state = 0;
    m_total = 0;
    m_ticks = 0;
    exp_move = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    total++;
    if ({move_tick, speed_level, sched_state} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async: got %b want 000000", {move_tick, speed_level, sched_state});
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    m_state = 0;
    m_total = 0;
    m_ticks = 0;
    cyc(1, 0, 0);
    total++;
    if ({move_tick, speed_level, sched_state} !== {exp_move, 3'(lvl(m_ticks)), 2'(m_state)}) begin
      bad++;
      $display("FAIL reset_idle_tick: got %b want %b", {move_tick, speed_level, sched_state}, {exp_move, 3'(lvl(m_ticks)), 2'(m_state)});
    end
  endtask

  task automatic test_idle();
    int cnt = 0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0);
      cnt += int'(move_tick);
      total++;
`ifdef SPEED_SCHED_ATTRACT_EN
      if (move_tick !== (k % 2 == 0) || sched_state !== 2'd0) begin
        bad++;
        $display("FAIL attract_tick%0d: got move=%b state=%0d want move=%b state=0", k, move_tick, sched_state, k % 2 == 0);
      end
`else
      if (move_tick !== 1'b0 || sched_state !== 2'd0) begin
        bad++;
        $display("FAIL idle_tick%0d: got move=%b state=%0d want move=0 state=0", k, move_tick, sched_state);
      end
`endif
    end
    total++;
    if (move_tick !== exp_move) begin
      bad++;
      $display("FAIL idle_model: got %b want %b", move_tick, exp_move);
    end
  endtask

  task automatic test_level0();
    int cnt = 0;
    do_reset();
    cyc(0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0);
      cnt += int'(move_tick);
      total++;
      if (move_tick !== (k % 2 == 0) || speed_level !== 3'd0 || sched_state !== 2'd1) begin
        bad++;
        $display("FAIL level0_tick%0d: got move=%b lvl=%0d st=%0d want move=%b lvl=0 st=1", k, move_tick, speed_level, sched_state, k % 2 == 0);
      end
      repeat ($urandom_range(0, 3)) begin
        cyc(0, 0, 0);
        total++;
        if (move_tick !== 1'b0) begin
          bad++;
          $display("FAIL level0_gap: got move=%b want 0", move_tick);
        end
      end
    end
    total++;
    if (cnt !== 5) begin
      bad++;
      $display("FAIL level0_count: got %0d want 5", cnt);
    end
  endtask

  task automatic test_levels();
    int c9 = 0;
    int c15 = 0;
    do_reset();
    cyc(0, 1, 0);
    for (int k = 1; k <= 4800; k++) begin
      cyc(1, 0, 0);
      total++;
      if ({move_tick, speed_level, sched_state} !== {exp_move, 3'(lvl(m_ticks)), 2'(m_state)}) begin
        bad++;
        $display("FAIL levels_tick%0d: got %b want %b", k, {move_tick, speed_level, sched_state}, {exp_move, 3'(lvl(m_ticks)), 2'(m_state)});
      end
      if (k == 599 || k == 600 || k == 4199 || k == 4200) begin
        total++;
        if (speed_level !== ((k == 599) ? 3'd0 : (k == 600) ? 3'd1 : (k == 4199) ? 3'd6 : 3'd7)) begin
          bad++;
          $display("FAIL levels_step_at%0d: got %0d", k, speed_level);
        end
      end
      if (k >= 601 && k <= 608) begin
        total++;
        if (move_tick !== (k % 2 == 0)) begin
          bad++;
          $display("FAIL levels_rate144_tick%0d: got %b want %b", k, move_tick, k % 2 == 0);
        end
      end
      if (k >= 601 && k <= 616) c9 += int'(move_tick);
      if (k >= 4785) c15 += int'(move_tick);
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 0);
    end
    total++;
    if (c9 !== 9) begin
      bad++;
      $display("FAIL levels_rate144_count: got %0d want 9", c9);
    end
    total++;
    if (c15 !== 15 || speed_level !== 3'd7) begin
      bad++;
      $display("FAIL levels_sat: got count=%0d lvl=%0d want count=15 lvl=7", c15, speed_level);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4 && !exp_move; i++) cyc(1, 0, 0);
    total++;
    if (move_tick !== 1'b1 || speed_level !== 3'd7) begin
      bad++;
      $display("FAIL arst_setup: got move=%b lvl=%0d want move=1 lvl=7", move_tick, speed_level);
    end
    game_tick = 1;
    rst_n = 0;
    #1;
    total++;
    if ({move_tick, speed_level, sched_state} !== 6'b0) begin
      bad++;
      $display("FAIL arst_immediate: got %b want 000000", {move_tick, speed_level, sched_state});
    end
    @(posedge clk);
    #1;
    total++;
    if (move_tick !== 1'b0) begin
      bad++;
      $display("FAIL arst_pending: got %b want 0", move_tick);
    end
    game_tick = 0;
    rst_n = 1;
    m_state = 0;
    m_total = 0;
    m_ticks = 0;
  endtask

  task automatic test_freeze();
    int cnt = 0;
    do_reset();
    cyc(0, 1, 0);
    repeat (600 + $urandom_range(0, 300)) cyc(1, 0, 0);
    cyc(1, 0, 1);
    total++;
    if (sched_state !== 2'd2 || move_tick !== 1'b0 || speed_level !== 3'd1) begin
      bad++;
      $display("FAIL freeze_enter: got st=%0d move=%b lvl=%0d want st=2 move=0 lvl=1", sched_state, move_tick, speed_level);
    end
    repeat (100) begin
      cyc(1, 0, 0);
      cnt += int'(move_tick);
    end
    total++;
    if (cnt !== 0 || speed_level !== 3'd1 || sched_state !== 2'd2) begin
      bad++;
      $display("FAIL freeze_hold: got moves=%0d lvl=%0d st=%0d want moves=0 lvl=1 st=2", cnt, speed_level, sched_state);
    end
    cyc(1, 1, 0);
    total++;
    if (sched_state !== 2'd1 || speed_level !== 3'd0 || move_tick !== 1'b0) begin
      bad++;
      $display("FAIL freeze_restart: got st=%0d lvl=%0d move=%b want st=1 lvl=0 move=0", sched_state, speed_level, move_tick);
    end
    cyc(1, 0, 0);
    cnt = int'(move_tick);
    cyc(1, 0, 0);
    total++;
    if (cnt !== 0 || move_tick !== 1'b1) begin
      bad++;
      $display("FAIL freeze_acc_cleared: got moves=%0d,%b want 0,1", cnt, move_tick);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(0, 1, 1);
    total++;
    if (sched_state !== 2'd0) begin
      bad++;
      $display("FAIL simul_idle: got st=%0d want 0", sched_state);
    end
    cyc(0, 1, 0);
    repeat (610) cyc(1, 0, 0);
    cyc(1, 1, 1);
    total++;
    if (sched_state !== 2'd2 || speed_level !== 3'd1 || move_tick !== 1'b0) begin
      bad++;
      $display("FAIL simul_run: got st=%0d lvl=%0d move=%b want st=2 lvl=1 move=0", sched_state, speed_level, move_tick);
    end
    cyc(0, 1, 1);
    total++;
    if (sched_state !== 2'd2 || speed_level !== 3'd1) begin
      bad++;
      $display("FAIL simul_frozen: got st=%0d lvl=%0d want st=2 lvl=1", sched_state, speed_level);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (3000) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
      total++;
      if ({move_tick, speed_level, sched_state} !== {exp_move, 3'(lvl(m_ticks)), 2'(m_state)}) begin
        bad++;
        $display("FAIL random: got %b want %b", {move_tick, speed_level, sched_state}, {exp_move, 3'(lvl(m_ticks)), 2'(m_state)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_level0();
    test_levels();
    test_async_reset();
    test_freeze();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
